// File: rtl/spmv_config_master.sv
// AXI4-Lite initiator that writes one kernel's row, nnz and ctrl registers in that order.
// Define SPMV_CFG_READBACK_EN to read all three back and flag any mismatch.
module spmv_config_master #(
  parameter int unsigned NUM_KERNEL     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned PER_ADDR_SPACE = 12,
  parameter logic [31:0] CTRL_OFFSET    = 32'h00,
  parameter logic [31:0] ROW_OFFSET     = 32'h04,
  parameter logic [31:0] NNZ_OFFSET     = 32'h08,
  localparam int unsigned KW = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1
) (
  input  logic          aclk_i,
  input  logic          areset_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [KW-1:0] cmd_kernel_i,
  input  logic [31:0]   cmd_ctrl_i,
  input  logic [31:0]   cmd_row_i,
  input  logic [31:0]   cmd_nnz_i,
  output logic          done_valid_o,
  output logic [1:0]    done_resp_o,
  output logic          done_mismatch_o,
  output logic          m_axil_awvalid_o,
  input  logic          m_axil_awready_i,
  output logic [31:0]   m_axil_awaddr_o,
  output logic          m_axil_wvalid_o,
  input  logic          m_axil_wready_i,
  output logic [31:0]   m_axil_wdata_o,
  input  logic          m_axil_bvalid_i,
  output logic          m_axil_bready_o,
  input  logic [1:0]    m_axil_bresp_i,
  output logic          m_axil_arvalid_o,
  input  logic          m_axil_arready_i,
  output logic [31:0]   m_axil_araddr_o,
  input  logic          m_axil_rvalid_i,
  output logic          m_axil_rready_o,
  input  logic [31:0]   m_axil_rdata_i,
  input  logic [1:0]    m_axil_rresp_i
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
`ifdef SPMV_CFG_READBACK_EN
    StRead,
    StRresp,
`endif
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [KW-1:0] kern_q, kern_d;
  logic [31:0]   ctrl_q, ctrl_d, row_q, row_d, nnz_q, nnz_d;
  logic [1:0]    err_q, err_d;
  logic          mism_q, mism_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic          bready_q, bready_d, rready_q, rready_d;
  logic          cmd_ready_q, cmd_ready_d, done_valid_q, done_valid_d;
  logic [1:0]    done_resp_q, done_resp_d;
  logic          done_mism_q, done_mism_d;

  // Step order is row, nnz, ctrl so ctrl always lands last.
  function automatic logic [31:0] step_addr(input logic [KW-1:0] k, input logic [1:0] s);
    logic [31:0] off;
    case (s)
      2'd0:    off = ROW_OFFSET;
      2'd1:    off = NNZ_OFFSET;
      default: off = CTRL_OFFSET;
    endcase
    return BASE_ADDR + 32'(k) * PER_ADDR_SPACE + off;
  endfunction

  function automatic logic [31:0] step_data(input logic [1:0] s, input logic [31:0] row,
                                            input logic [31:0] nnz, input logic [31:0] ctrl);
    case (s)
      2'd0:    return row;
      2'd1:    return nnz;
      default: return ctrl;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    kern_d    = kern_q;
    ctrl_d    = ctrl_q;
    row_d     = row_q;
    nnz_d     = nnz_q;
    err_d     = err_q;
    mism_d    = mism_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          kern_d = cmd_kernel_i;
          ctrl_d = cmd_ctrl_i;
          row_d  = cmd_row_i;
          nnz_d  = cmd_nnz_i;
          step_d = 2'd0;
          err_d  = 2'b00;
          mism_d = 1'b0;
          if (32'(cmd_kernel_i) >= NUM_KERNEL) begin
            err_d   = 2'b10;
            state_d = StDone;
          end else begin
            state_d   = StWrite;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = step_addr(cmd_kernel_i, 2'd0);
            wdata_d   = cmd_row_i;
          end
        end
      end
      StWrite: begin
        if (m_axil_awready_i) awvalid_d = 1'b0;
        if (m_axil_wready_i) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = StWresp;
      end
      StWresp: begin
        if (bready_q && m_axil_bvalid_i) begin
          if (m_axil_bresp_i != 2'b00) begin
            err_d   = m_axil_bresp_i;
            state_d = StDone;
          end else if (step_q < 2'd2) begin
            step_d    = step_q + 2'd1;
            state_d   = StWrite;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = step_addr(kern_q, step_q + 2'd1);
            wdata_d   = step_data(step_q + 2'd1, row_q, nnz_q, ctrl_q);
          end else begin
`ifdef SPMV_CFG_READBACK_EN
            step_d    = 2'd0;
            state_d   = StRead;
            arvalid_d = 1'b1;
            araddr_d  = step_addr(kern_q, 2'd0);
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef SPMV_CFG_READBACK_EN
      StRead: begin
        if (m_axil_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = StRresp;
        end
      end
      StRresp: begin
        if (rready_q && m_axil_rvalid_i) begin
          if (m_axil_rresp_i != 2'b00) begin
            err_d   = m_axil_rresp_i;
            state_d = StDone;
          end else begin
            if (m_axil_rdata_i != step_data(step_q, row_q, nnz_q, ctrl_q)) mism_d = 1'b1;
            if (step_q < 2'd2) begin
              step_d    = step_q + 2'd1;
              state_d   = StRead;
              arvalid_d = 1'b1;
              araddr_d  = step_addr(kern_q, step_q + 2'd1);
            end else begin
              state_d = StDone;
            end
          end
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Handshake-side outputs are registered from the next state.
    cmd_ready_d  = (state_d == StIdle);
    bready_d     = (state_d == StWresp);
`ifdef SPMV_CFG_READBACK_EN
    rready_d     = (state_d == StRresp);
`else
    rready_d     = 1'b0;
`endif
    done_valid_d = (state_d == StDone);
    done_resp_d  = (state_d == StDone) ? err_d : 2'b00;
    done_mism_d  = (state_d == StDone) ? mism_d : 1'b0;
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q      <= StIdle;
      step_q       <= 2'd0;
      kern_q       <= '0;
      ctrl_q       <= '0;
      row_q        <= '0;
      nnz_q        <= '0;
      err_q        <= 2'b00;
      mism_q       <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      araddr_q     <= '0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_resp_q  <= 2'b00;
      done_mism_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      kern_q       <= kern_d;
      ctrl_q       <= ctrl_d;
      row_q        <= row_d;
      nnz_q        <= nnz_d;
      err_q        <= err_d;
      mism_q       <= mism_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      araddr_q     <= araddr_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      cmd_ready_q  <= cmd_ready_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
      done_mism_q  <= done_mism_d;
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign done_valid_o     = done_valid_q;
  assign done_resp_o      = done_resp_q;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_awaddr_o  = awaddr_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_bready_o  = bready_q;
  assign m_axil_araddr_o  = araddr_q;

`ifdef SPMV_CFG_READBACK_EN
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = rready_q;
  assign done_mismatch_o  = done_mism_q;
`else
  logic unused_rd;
  assign unused_rd = ^{m_axil_arready_i, m_axil_rvalid_i, m_axil_rdata_i, m_axil_rresp_i,
                       arvalid_q, rready_q, done_mism_q};
  assign m_axil_arvalid_o = 1'b0;
  assign m_axil_rready_o  = 1'b0;
  assign done_mismatch_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spmv_config_master.sv
// Directed bench for spmv_config_master with a reactive AXI-Lite slave and write/done scoreboards.
module tb_spmv_config_master;

  localparam int unsigned NK = 3;
`ifdef SPMV_CFG_READBACK_EN
  localparam int LatOk = 13;
  localparam int RdPerCmd = 3;
`else
  localparam int LatOk = 7;
  localparam int RdPerCmd = 0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_kernel;
  logic [31:0] cmd_ctrl, cmd_row, cmd_nnz;
  logic        done_valid, done_mismatch;
  logic [1:0]  done_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;

  spmv_config_master #(.NUM_KERNEL(NK)) dut (
    .aclk_i(clk), .areset_i(areset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_kernel_i(cmd_kernel),
    .cmd_ctrl_i(cmd_ctrl), .cmd_row_i(cmd_row), .cmd_nnz_i(cmd_nnz),
    .done_valid_o(done_valid), .done_resp_o(done_resp), .done_mismatch_o(done_mismatch),
    .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready), .m_axil_awaddr_o(awaddr),
    .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready), .m_axil_wdata_o(wdata),
    .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready), .m_axil_bresp_i(bresp),
    .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready), .m_axil_araddr_o(araddr),
    .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready), .m_axil_rdata_i(rdata),
    .m_axil_rresp_i(rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [1:0] resp; logic mism; int lat;} done_t;
  wr_t   wq[$];
  done_t dq[$];

  int n_pass = 0, n_total = 0, n_fail = 0;
  int t_acc = 0;
  int wr_count = 0, rd_count = 0, act_cnt = 0;
  int bresp_err_idx = -1;
  int wready_delay = 0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k, input int s);
    logic [31:0] off;
    off = (s == 0) ? 32'h04 : (s == 1) ? 32'h08 : 32'h00;
    return 32'(k) * 32'd12 + off;
  endfunction

  // Reactive slave, driven on the falling edge; *_hs flags predict the next rising edge.
  logic        aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic        got_aw = 0, got_w = 0;
  logic [31:0] aw_a_s, w_d_s, ar_a_s, aw_a, w_d;
  logic [31:0] mem [logic [31:0]];
  int          wdly = 0;

  initial begin
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  end

  always @(negedge clk) begin
    if (areset) begin
      bvalid = 1'b0; rvalid = 1'b0; wready = (wready_delay == 0);
      got_aw = 0; got_w = 0; wdly = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    end else begin
      if (wdly > 0) begin
        wdly--;
        if (wdly == 0) wready = 1'b1;
      end
      if (aw_hs) begin
        got_aw = 1; aw_a = aw_a_s;
        if (wready_delay > 0 && !w_hs) wdly = wready_delay;
      end
      if (w_hs) begin
        got_w = 1; w_d = w_d_s; wready = (wready_delay == 0);
      end
      if (b_hs) bvalid = 1'b0;
      if (r_hs) rvalid = 1'b0;
      if (ar_hs) begin
        rvalid = 1'b1;
        rdata = (ar_a_s == corrupt_addr) ? 32'd99 : (mem.exists(ar_a_s) ? mem[ar_a_s] : 32'd0);
        rd_count++;
      end
      if (got_aw && !got_w) begin
        check("aw_dropped_after_hs", {31'd0, awvalid}, 32'd0);
        check("w_held_until_hs", {31'd0, wvalid}, 32'd1);
      end
      if (got_aw && got_w) begin
        check("write_expected", {31'd0, wq.size() != 0}, 32'd1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          check("write_addr", aw_a, e.addr);
          check("write_data", w_d, e.data);
        end
        mem[aw_a] = w_d;
        bvalid = 1'b1;
        bresp = (wr_count == bresp_err_idx) ? 2'b10 : 2'b00;
        wr_count++;
        got_aw = 0; got_w = 0;
      end
      if (done_valid) begin
        check("done_expected", {31'd0, dq.size() != 0}, 32'd1);
        if (dq.size() != 0) begin
          done_t d;
          d = dq.pop_front();
          check("done_resp", {30'd0, done_resp}, {30'd0, d.resp});
          check("done_mismatch", {31'd0, done_mismatch}, {31'd0, d.mism});
          if (d.lat >= 0) check("done_latency", cyc - t_acc, d.lat);
        end
      end
      if (awvalid || wvalid || arvalid) act_cnt++;
      aw_hs = awvalid && awready; aw_a_s = awaddr;
      w_hs = wvalid && wready; w_d_s = wdata;
      b_hs = bvalid && bready;
      ar_hs = arvalid && arready; ar_a_s = araddr;
      r_hs = rvalid && rready;
    end
  end

  task automatic send_cmd(input int k, input logic [31:0] c, input logic [31:0] r,
                          input logic [31:0] n, input int err_idx, input int lat);
    done_t d;
    logic [31:0] vals[3];
    bool_loop: begin end
    vals[0] = r; vals[1] = n; vals[2] = c;
    bresp_err_idx = err_idx;
    wr_count = 0;
    rd_count = 0;
    d.mism = 1'b0;
    d.lat = lat;
    if (k >= int'(NK)) begin
      d.resp = 2'b10;
    end else begin
      for (int i = 0; i < 3; i++) begin
        wq.push_back('{addr: exp_addr(k, i), data: vals[i]});
        if (i == err_idx) break;
      end
      d.resp = (err_idx >= 0) ? 2'b10 : 2'b00;
`ifdef SPMV_CFG_READBACK_EN
      if (err_idx < 0)
        for (int i = 0; i < 3; i++) if (exp_addr(k, i) == corrupt_addr) d.mism = 1'b1;
`endif
    end
    dq.push_back(d);
    cmd_kernel = 2'(k); cmd_ctrl = c; cmd_row = r; cmd_nnz = n;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    check("cmd_accepted", {31'd0, cmd_ready}, 32'd1);
    t_acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    logic seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_all_reset(input string tag);
    check(tag, {awvalid, wvalid, bready, arvalid, rready, cmd_ready, done_valid, done_resp,
                done_mismatch}, 32'd0);
    check({tag, "_addr"}, awaddr | wdata | araddr, 32'd0);
  endtask

  initial begin
    int act0;
    areset = 1'b1; cmd_valid = 1'b0; cmd_kernel = '0;
    cmd_ctrl = '0; cmd_row = '0; cmd_nnz = '0;
    repeat (3) @(negedge clk);
    check_all_reset("reset_outputs");
    areset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Kernel 2, zero-wait slave.
    send_cmd(2, 32'd1, 32'd100, 32'd500, -1, LatOk);
    wait_done(40);
    @(negedge clk);
    check("k2_writes_drained", wq.size(), 32'd0);
    check("k2_reads", rd_count, RdPerCmd);

    // wready lags awready by three cycles on every write.
    wready_delay = 3; wready = 1'b0;
    send_cmd(1, 32'h5, 32'hABCD, 32'h1234, -1, -1);
    wait_done(80);
    @(negedge clk);
    wready_delay = 0; wready = 1'b1;
    check("slow_w_writes_drained", wq.size(), 32'd0);

    // SLVERR on the nnz write: ctrl is skipped.
    send_cmd(0, 32'h7, 32'd11, 32'd22, 1, 5);
    wait_done(40);
    check("cmd_ready_in_done", {31'd0, cmd_ready}, 32'd0);
    act0 = act_cnt;
    @(negedge clk);
    check("cmd_ready_after_done", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("err_no_more_bus", act_cnt - act0, 32'd0);
    check("err_writes_drained", wq.size(), 32'd0);
    check("err_write_count", wr_count, 32'd2);

    // Out-of-range kernel.
    act0 = act_cnt;
    send_cmd(3, 32'd1, 32'd2, 32'd3, -1, 1);
    wait_done(10);
    @(negedge clk);
    check("bad_kernel_no_bus", act_cnt - act0, 32'd0);

`ifdef SPMV_CFG_READBACK_EN
    corrupt_addr = 32'h1C;
    send_cmd(2, 32'd1, 32'd100, 32'd500, -1, LatOk);
    wait_done(40);
    @(negedge clk);
    corrupt_addr = 32'hFFFF_FFFF;
    check("rb_reads", rd_count, 32'd3);
`endif

    // Reset while waiting on the write response.
    send_cmd(1, 32'd9, 32'd8, 32'd7, -1, LatOk);
    for (int i = 0; i < 20; i++) begin
      if (bready) break;
      @(negedge clk);
    end
    check("reached_wresp", {31'd0, bready}, 32'd1);
    areset = 1'b1;
    wq.delete();
    dq.delete();
    @(negedge clk);
    check_all_reset("midseq_reset");
    areset = 1'b0;
    @(negedge clk);
    send_cmd(2, 32'd3, 32'd64, 32'd128, -1, LatOk);
    wait_done(40);
    @(negedge clk);
    check("post_reset_drained", wq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
